axi_wr_to_mem: RTL and testbench
================================

AXI_WR_TO_MEM -- requirements
Module: axi_wr_to_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning W data width in bits (8,16,32,64,128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, meaning byte-strobe width.
REQ-004 SHALL have parameter ID_WIDTH, default 8, meaning AXI ID width.
REQ-005 SHALL have the port clk, input, 1, meaning sole clock; all logic on rising edge.
REQ-006 SHALL have the port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have the port s_axi_awid, input, ID_WIDTH, meaning write address ID.
REQ-008 SHALL have the port s_axi_awaddr, input, ADDR_WIDTH, meaning burst start byte address.
REQ-009 SHALL have the port s_axi_awlen, input, 8, meaning beats minus one.
REQ-010 SHALL have the port s_axi_awburst, input, 2, meaning 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-011 SHALL have the port s_axi_awvalid/s_axi_awready, input/output, 1/1, meaning AW handshake.
REQ-012 SHALL have the port s_axi_wdata/s_axi_wstrb, input, DATA_WIDTH/STRB_WIDTH, meaning beat data and byte enables.
REQ-013 SHALL have the port s_axi_wlast, input, 1, meaning master-flagged last beat.
REQ-014 SHALL have the port s_axi_wvalid/s_axi_wready, input/output, 1/1, meaning W handshake.
REQ-015 SHALL have the port s_axi_bid/s_axi_bresp, output, ID_WIDTH/2, meaning response ID and code.
REQ-016 SHALL have the port s_axi_bvalid/s_axi_bready, output/input, 1/1, meaning B handshake.
REQ-017 SHALL have the port mem_wr_en, output, 1, meaning one-cycle memory write strobe.
REQ-018 SHALL have the port mem_addr, output, ADDR_WIDTH-log2(STRB_WIDTH), meaning word address (byte address >> log2(STRB_WIDTH)).
REQ-019 SHALL have the port mem_wdata/mem_wstrb, output, DATA_WIDTH/STRB_WIDTH, meaning registered beat data and strobes.

Function
REQ-020 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, with one outstanding write burst.
REQ-021 SHALL, in IDLE, drive awready=1 and wready=0; on awvalid&awready, latch id, addr, len and burst, clear the beat counter and error flag, and enter DATA.
REQ-022 SHALL, in DATA, drive awready=0 and wready=1; each wvalid&wready beat registers mem_wr_en=1, mem_addr, mem_wdata and mem_wstrb on the next cycle (latency 1), otherwise mem_wr_en=0.
REQ-023 SHALL advance the address per beat: FIXED holds; INCR adds STRB_WIDTH bytes, wrapping modulo 2^ADDR_WIDTH; WRAP per REQ-033.
REQ-024 SHALL end the burst on beat len+1 regardless of wlast, drop wready in the same cycle, and enter RESP.
REQ-025 SHALL set the error flag when wlast=1 on a beat other than beat len+1, or wlast=0 on beat len+1; no early termination.
REQ-026 SHALL treat awburst=3 as an error: beats drained, mem_wr_en suppressed, bresp=SLVERR.
REQ-027 SHALL, in RESP, hold bvalid=1, bid=latched id, bresp=2'b10 if the error flag is set else 2'b00, stable until bready; on bvalid&bready enter IDLE next cycle.
REQ-028 SHALL ignore awsize (full-width beats only) and not check 4 KB crossings.
REQ-029 SHALL accept a new AW in the cycle after the B handshake completes, giving a minimum of 2 idle cycles between bursts.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE and awready, wready, bvalid, bid, bresp, mem_wr_en, mem_addr, mem_wdata and mem_wstrb all to 0, immediately and independent of clk.
REQ-031 SHALL raise awready on the first clk edge after rst_n deasserts.
REQ-032 SHALL, when reset is asserted mid-burst or mid-response, discard the burst with no B response and no further mem_wr_en.

Configuration
REQ-033 SHALL, with macro AXI_WR_WRAP_EN defined, support WRAP: len must be 1, 3, 7 or 15, else error per REQ-026; the address increments by STRB_WIDTH within a window of (len+1)*STRB_WIDTH bytes aligned to that size, wrapping to the window base.
REQ-034 SHALL, without AXI_WR_WRAP_EN, treat awburst=2 as an error per REQ-026.

Verification (DATA_WIDTH=32)
REQ-035 SHALL cover: INCR awaddr=0x100, len=3, data 0x11..0x44, wlast on beat 4 -> mem_addr 0x40..0x43, four mem_wr_en pulses, bresp=0, bid echoed.
REQ-036 SHALL cover: FIXED awaddr=0x20, len=2 -> three writes to mem_addr 0x08, bresp=0.
REQ-037 SHALL cover: WRAP awaddr=0x38, len=3 with the macro -> mem_addr 0x0E,0x0F,0x0C,0x0D, bresp=0; without the macro -> no mem_wr_en, bresp=2.
REQ-038 SHALL cover: INCR len=1 with wlast on beat 1 -> both beats written, bresp=2.
REQ-039 SHALL cover: bready held 0 for 5 cycles -> bvalid, bid and bresp stable, awready=0 throughout, awready=1 the cycle after the B handshake.
REQ-040 SHALL cover: rst_n pulled low at beat 2 of a len=7 burst -> all outputs 0 asynchronously, no B response, next burst correct.

Source files
------------

// File: rtl/axi_wr_to_mem.sv
// -----------------------------------------------------------------------------
// axi_wr_to_mem
//
// AXI4 write-channel slave that turns one write burst at a time into
// single-cycle memory write strobes. Only one burst is in flight at a time.
// The bursts follow IDLE -> DATA -> RESP -> IDLE. Every beat is a full-width
// beat, because awsize is not used.
//
// Optional feature macro: AXI_WR_WRAP_EN
//   defined   : WRAP bursts are supported when len is 1, 3, 7 or 15.
//               Any other WRAP len is answered with SLVERR.
//   undefined : WRAP bursts are answered with SLVERR.
//               Their beats are drained and nothing is written.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   s_axi_aw*               write address channel (id, addr, len, burst)
//   s_axi_w*                write data channel (data, strb, last)
//   s_axi_b*                write response channel (id, resp)
//   mem_wr_en               one-cycle write strobe, 1 cycle after a W beat
//   mem_addr                word address (byte address >> log2(STRB_WIDTH))
//   mem_wdata, mem_wstrb    registered beat data and byte enables
//   dbg_state               current FSM state (0 IDLE, 1 DATA, 2 RESP)
//
// Handshake rule for every channel:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   This slave never makes its ready depend on the master's valid.
//   bvalid, bid and bresp stay stable until bready is seen.
// -----------------------------------------------------------------------------
module axi_wr_to_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [ID_WIDTH-1:0]                       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]                     s_axi_awaddr,
  input  logic [7:0]                                s_axi_awlen,
  input  logic [1:0]                                s_axi_awburst,
  input  logic                                      s_axi_awvalid,
  output logic                                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                     s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]                     s_axi_wstrb,
  input  logic                                      s_axi_wlast,
  input  logic                                      s_axi_wvalid,
  output logic                                      s_axi_wready,
  output logic [ID_WIDTH-1:0]                       s_axi_bid,
  output logic [1:0]                                s_axi_bresp,
  output logic                                      s_axi_bvalid,
  input  logic                                      s_axi_bready,
  output logic                                      mem_wr_en,
  output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]                     mem_wdata,
  output logic [STRB_WIDTH-1:0]                     mem_wstrb,
  output logic [1:0]                                dbg_state
);

  localparam int ADDR_SH = $clog2(STRB_WIDTH);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  // run_q is 1 from the first clock edge after reset is released.
  // It keeps awready low while reset is held, even though the state is IDLE.
  logic                    run_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [1:0]              burst_q;
  logic [7:0]              beat_q;
  logic                    err_q;
  logic                    bad_q;

  logic                    aw_fire;
  logic                    w_fire;
  logic                    b_fire;
  logic                    last_beat;
  logic                    aw_bad;
  logic [ADDR_WIDTH-1:0]   addr_nxt;

  assign aw_fire   = s_axi_awvalid & s_axi_awready;
  assign w_fire    = s_axi_wvalid & s_axi_wready;
  assign b_fire    = s_axi_bvalid & s_axi_bready;
  assign last_beat = (beat_q == len_q);
  assign dbg_state = state_q;

  // A burst type this build cannot carry still has its beats accepted.
  // Those beats are simply not written to memory.
  always_comb begin
    aw_bad = 1'b0;
    case (s_axi_awburst)
      BURST_FIXED, BURST_INCR: aw_bad = 1'b0;
`ifdef AXI_WR_WRAP_EN
      BURST_WRAP: aw_bad = !((s_axi_awlen == 8'd1) || (s_axi_awlen == 8'd3) ||
                             (s_axi_awlen == 8'd7) || (s_axi_awlen == 8'd15));
`else
      BURST_WRAP: aw_bad = 1'b1;
`endif
      default: aw_bad = 1'b1;
    endcase
  end

`ifdef AXI_WR_WRAP_EN
  // len+1 is a power of two, so the window mask is (len << sh) | (STRB_WIDTH-1).
  logic [ADDR_WIDTH-1:0] wrap_mask;
  assign wrap_mask = (ADDR_WIDTH'(len_q) << ADDR_SH) | ADDR_WIDTH'(STRB_WIDTH - 1);
`endif

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      BURST_INCR: addr_nxt = addr_q + ADDR_WIDTH'(STRB_WIDTH);
`ifdef AXI_WR_WRAP_EN
      BURST_WRAP: addr_nxt = (addr_q & ~wrap_mask) |
                             ((addr_q + ADDR_WIDTH'(STRB_WIDTH)) & wrap_mask);
`endif
      default:    addr_nxt = addr_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_fire) state_d = ST_DATA;
      ST_DATA: if (w_fire && last_beat) state_d = ST_RESP;
      ST_RESP: if (b_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bid     = '0;
    s_axi_bresp   = RESP_OKAY;
    case (state_q)
      ST_IDLE: s_axi_awready = run_q;
      ST_DATA: s_axi_wready  = 1'b1;
      ST_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = id_q;
        s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Burst context and memory-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      run_q     <= 1'b1;
      mem_wr_en <= 1'b0;
      if (aw_fire) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr;
        len_q   <= s_axi_awlen;
        burst_q <= s_axi_awburst;
        beat_q  <= '0;
        err_q   <= aw_bad;
        bad_q   <= aw_bad;
      end
      if (w_fire) begin
        if (!bad_q) begin
          mem_wr_en <= 1'b1;
          mem_addr  <= addr_q[ADDR_WIDTH-1:ADDR_SH];
          mem_wdata <= s_axi_wdata;
          mem_wstrb <= s_axi_wstrb;
        end
        addr_q <= addr_nxt;
        beat_q <= beat_q + 8'd1;
        // A wlast on the wrong beat, or a missing wlast, is reported in bresp.
        // The burst length is still taken from len.
        if (s_axi_wlast != last_beat) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_to_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_to_mem
//
// Testbench for axi_wr_to_mem with DATA_WIDTH=32. It covers:
//   - directed bursts: INCR, FIXED, WRAP, a bad-wlast burst, a stalled B
//     response, and a reset pulled in the middle of a burst;
//   - a batch of random bursts.
//
// Expected memory writes and B responses are pushed into queues when a burst
// is issued. A monitor pops and compares them as the DUT presents them.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_wr_to_mem;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IW-1:0]   s_axi_awid = '0;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic [7:0]      s_axi_awlen = '0;
  logic [1:0]      s_axi_awburst = '0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata = '0;
  logic [SW-1:0]   s_axi_wstrb = '0;
  logic            s_axi_wlast = 1'b0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [IW-1:0]   s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic            mem_wr_en;
  logic [AW-3:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [SW-1:0]   mem_wstrb;
  logic [1:0]      dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  axi_wr_to_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected write entry: {word address, data, strb} (30+32+4 bits).
  // Expected response entry: {id, resp}.
  logic [65:0] exp_w_q[$];
  logic [9:0]  exp_b_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit burst_legal(input logic [1:0] burst, input logic [7:0] len);
    if (burst == 2'd0 || burst == 2'd1) return 1'b1;
`ifdef AXI_WR_WRAP_EN
    if (burst == 2'd2) return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`endif
    return 1'b0;
  endfunction

  // Byte address of beat i, computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] size;
    logic [31:0] base;
    case (burst)
      2'd0: return start;
      2'd1: return start + 32'(4 * i);
      default: begin
        size = (32'(len) + 32'd1) * 32'd4;
        base = start - (start % size);
        return base + ((start - base + 32'(4 * i)) % size);
      end
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [65:0] ew;
    logic [9:0]  eb;
    if (rst_n && mem_wr_en) begin
      if (exp_w_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_write: got unexpected write addr %0h data %0h, none required",
                 mem_addr, mem_wdata);
      end else begin
        ew = exp_w_q.pop_front();
        check("mem_write", {30'd0, mem_addr, mem_wdata, mem_wstrb}, {30'd0, ew});
      end
    end
    // bready was driven just after the previous rising edge, so this
    // transfer happens on the next rising edge.
    if (rst_n && s_axi_bvalid && s_axi_bready) begin
      if (exp_b_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_resp: got unexpected response id %0h resp %0h, none required",
                 s_axi_bid, s_axi_bresp);
      end else begin
        eb = exp_b_q.pop_front();
        check("b_resp", {86'd0, s_axi_bid, s_axi_bresp}, {86'd0, eb});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (s_axi_awready) begin
        tick();
        s_axi_awvalid = 1'b0;
        return;
      end
      tick();
    end
    n_cmp++; n_bad++;
    $display("FAIL aw_timeout: got awready=0 for 50 cycles, required 1");
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] strb,
                           input logic last, input int max_gap);
    repeat ($urandom_range(0, max_gap)) tick();
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (s_axi_wready) begin
        tick();
        s_axi_wvalid = 1'b0;
        return;
      end
      tick();
    end
    n_cmp++; n_bad++;
    $display("FAIL w_timeout: got wready=0 for 50 cycles, required 1");
    s_axi_wvalid = 1'b0;
  endtask

  task automatic take_b(input int delay);
    logic [9:0] b0;
    int t;
    for (t = 0; t < 100; t++) begin
      if (s_axi_bvalid) break;
      tick();
    end
    if (t == 100) begin
      n_cmp++; n_bad++;
      $display("FAIL b_timeout: got bvalid=0 for 100 cycles, required 1");
      return;
    end
    b0 = {s_axi_bid, s_axi_bresp};
    for (int k = 0; k < delay; k++) begin
      check("b_stable", {85'd0, s_axi_bvalid, s_axi_bid, s_axi_bresp}, {85'd0, 1'b1, b0});
      check("awready_in_resp", {95'd0, s_axi_awready}, 96'd0);
      tick();
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("awready_after_b", {95'd0, s_axi_awready}, 96'd1);
  endtask

  // Issue one burst and push its expected writes and response.
  // flip_idx >= 0 inverts wlast on that beat.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int flip_idx, input int b_delay,
                           input bit seq_data);
    logic [31:0] d [256];
    logic [3:0]  s [256];
    logic        l [256];
    logic [31:0] ba;
    bit          legal;
    bit          err;
    legal = burst_legal(burst, len);
    err = !legal;
    for (int i = 0; i <= int'(len); i++) begin
      d[i] = seq_data ? 32'(8'h11 * (i + 1)) : $urandom;
      s[i] = seq_data ? 4'hF : 4'($urandom_range(0, 15));
      l[i] = (i == int'(len)) ^ (i == flip_idx);
      if (l[i] != (i == int'(len))) err = 1'b1;
      if (legal) begin
        ba = beat_addr(addr, len, burst, i);
        exp_w_q.push_back({ba[31:2], d[i], s[i]});
      end
    end
    exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
    send_aw(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) send_beat(d[i], s[i], l[i], seq_data ? 0 : 2);
    take_b(b_delay);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {16'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
                 mem_wr_en, mem_addr, mem_wdata, mem_wstrb}, 96'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] d0;
    logic [31:0] d1;
    int          flip;

    #2;
    check_all_zero("reset_outputs");
    repeat (3) tick();
    rst_n = 1'b1;
    check("awready_before_edge", {95'd0, s_axi_awready}, 96'd0);
    tick();
    check("awready_after_reset", {95'd0, s_axi_awready}, 96'd1);

    // INCR at 0x100, 4 beats, data 0x11..0x44
    run_burst(8'h5A, 32'h100, 8'd3, 2'd1, -1, 0, 1'b1);
    // FIXED at 0x20, 3 beats, all to word 0x08
    run_burst(8'h21, 32'h20, 8'd2, 2'd0, -1, 0, 1'b1);
    // WRAP at 0x38, 4 beats
    run_burst(8'h37, 32'h38, 8'd3, 2'd2, -1, 1, 1'b1);
    // INCR with wlast on the first beat of two
    run_burst(8'h44, 32'h200, 8'd1, 2'd1, 0, 0, 1'b1);
    // stalled B response
    run_burst(8'hC3, 32'h300, 8'd0, 2'd1, -1, 5, 1'b0);
    // reserved burst type
    run_burst(8'h0F, 32'h400, 8'd2, 2'd3, -1, 0, 1'b0);
    // INCR across the top of the address space
    run_burst(8'h99, 32'hFFFF_FFF8, 8'd3, 2'd1, -1, 0, 1'b0);

    // Reset during beat 2 of an 8-beat burst. Only the first two beats are
    // written, and no response is returned.
    d0 = $urandom;
    d1 = $urandom;
    exp_w_q.push_back({30'h0000_0140, d0, 4'hF});
    exp_w_q.push_back({30'h0000_0141, d1, 4'hF});
    send_aw(8'h77, 32'h500, 8'd7, 2'd1);
    send_beat(d0, 4'hF, 1'b0, 0);
    send_beat(d1, 4'hF, 1'b0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    repeat (3) tick();
    check_all_zero("held_reset_outputs");
    rst_n = 1'b1;
    tick();
    check("awready_after_midreset", {95'd0, s_axi_awready}, 96'd1);
    run_burst(8'h78, 32'h600, 8'd2, 2'd1, -1, 0, 1'b1);

    // random bursts
    for (int n = 0; n < 40; n++) begin
      burst = 2'($urandom_range(0, 3));
      if (burst == 2'd2 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      run_burst(8'($urandom), $urandom, len, burst, flip, int'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    check("writes_left", 96'(exp_w_q.size()), 96'd0);
    check("resps_left", 96'(exp_b_q.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
